// File: rtl/sram_arbiter_if.sv
// Requester-side bus for sram_arbiter: level request with command fields, returning read data and an ack pulse.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wdata;
    logic [7:0]            rdata;
    logic                  ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter sequencing fixed-length accesses to an external async 8-bit SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN for port-A priority with B starvation relief; default is round-robin.
module sram_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_arbiter_if.slave         port_a,
    sram_arbiter_if.slave         port_b,
    output logic [ADDR_WIDTH-1:0] sramAddress,
    output logic [7:0]            sramDataOut,
    output logic                  sramDataOe,
    input  logic [7:0]            sramDataIn,
    output logic                  n_sRamCS,
    output logic                  n_sRamOE,
    output logic                  n_sRamWE
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  cur_grant_b;
    logic                  cur_we;
    logic                  grant_b;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_wdata;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic [2:0]            starve_cnt;

    // B only wins contention once A has taken four grants in a row while B waited
    always_comb begin
        grant_b = port_b.req && (!port_a.req || starve_cnt == 3'd4);
    end
`else
    logic                  last_grant_b;

    always_comb begin
        grant_b = port_b.req && (!port_a.req || !last_grant_b);
    end
`endif

    always_comb begin
        sel_we    = grant_b ? port_b.we    : port_a.we;
        sel_addr  = grant_b ? port_b.addr  : port_a.addr;
        sel_wdata = grant_b ? port_b.wdata : port_a.wdata;
    end

    // Strobes are registered one state ahead so each takes effect in the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            cur_grant_b  <= 1'b0;
            cur_we       <= 1'b0;
            sramAddress  <= '0;
            sramDataOut  <= 8'h00;
            sramDataOe   <= 1'b0;
            n_sRamCS     <= 1'b1;
            n_sRamOE     <= 1'b1;
            n_sRamWE     <= 1'b1;
            port_a.ack   <= 1'b0;
            port_b.ack   <= 1'b0;
            port_a.rdata <= 8'h00;
            port_b.rdata <= 8'h00;
`ifdef SRAM_ARB_FIXED_PRIO_EN
            starve_cnt   <= 3'd0;
`else
            last_grant_b <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (port_a.req || port_b.req) begin
                        cur_grant_b <= grant_b;
                        cur_we      <= sel_we;
                        sramAddress <= sel_addr;
                        n_sRamCS    <= 1'b0;
                        wait_cnt    <= 4'd0;
                        if (sel_we) begin
                            sramDataOe  <= 1'b1;
                            sramDataOut <= sel_wdata;
                        end else begin
                            n_sRamOE <= 1'b0;
                        end
`ifdef SRAM_ARB_FIXED_PRIO_EN
                        if (grant_b || !port_b.req) begin
                            starve_cnt <= 3'd0;
                        end else begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
`else
                        last_grant_b <= grant_b;
`endif
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cur_we) begin
                        n_sRamWE <= 1'b0;
                    end
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == LAST_CNT) begin
                        n_sRamWE <= 1'b1;
                        n_sRamOE <= 1'b1;
                        if (cur_grant_b) begin
                            port_b.ack <= 1'b1;
                            if (!cur_we) begin
                                port_b.rdata <= sramDataIn;
                            end
                        end else begin
                            port_a.ack <= 1'b1;
                            if (!cur_we) begin
                                port_a.rdata <= sramDataIn;
                            end
                        end
                        state <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    port_a.ack <= 1'b0;
                    port_b.ack <= 1'b0;
                    n_sRamCS   <= 1'b1;
                    sramDataOe <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
